// File: rtl/weight_memory_bank.sv
// weight_memory_bank: parametrised weight store with registered read, clear engine and burst stream
module weight_memory_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr,
  input  logic              strm_start,
  input  logic [ADDR_W-1:0] strm_base,
  input  logic [ADDR_W:0]   strm_len,
  output logic [DATA_W-1:0] strm_data,
  output logic              strm_valid,
  input  logic              strm_ready,
  output logic              strm_last,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic boot;
  logic [ADDR_W-1:0] clr_ptr, ptr;
  logic [ADDR_W:0] cnt;
  logic len_ok, go_clr, go_strm, go_rd, load, clr_done, strm_done;
  // command decode, priority clr > strm_start > rd_en, and next-state selection
  always_comb begin
    len_ok = strm_len != '0 && strm_len <= (ADDR_W+1)'(DEPTH);
    go_clr = state == IDLE && (clr || (boot && CLEAR_ON_RESET));
    go_strm = state == IDLE && !go_clr && strm_start && len_ok;
    go_rd = state == IDLE && !go_clr && !go_strm && rd_en;
    load = state == STREAM && (!strm_valid || strm_ready);
    clr_done = state == CLEAR && clr_ptr == ADDR_W'(DEPTH - 1);
    strm_done = state == STREAM && strm_valid && strm_ready && strm_last;
    state_nxt = go_clr ? CLEAR : go_strm ? STREAM : (clr_done || strm_done) ? IDLE : state;
    busy = state != IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // storage array is never reset; the clear engine owns the write port while clearing
  always_ff @(posedge clk)
    if (state == CLEAR) mem[clr_ptr] <= '0;
    else if (wr_en) mem[wr_addr] <= wr_data;
  // read port, clear pointer and stream output register; first word is fetched on acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      boot <= 1'b1;
      clr_ptr <= '0;
      ptr <= '0;
      cnt <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      strm_data <= '0;
      strm_valid <= 1'b0;
      strm_last <= 1'b0;
    end else begin
      boot <= 1'b0;
      rd_valid <= go_rd;
      if (go_rd) rd_data <= mem[rd_addr];
      clr_ptr <= state == CLEAR ? clr_ptr + 1'b1 : '0;
      if (go_strm) begin
        strm_data <= mem[strm_base];
        strm_valid <= 1'b1;
        strm_last <= strm_len == (ADDR_W+1)'(1);
        ptr <= strm_base + 1'b1;
        cnt <= strm_len - 1'b1;
      end else if (load) begin
        if (cnt != '0) begin
          strm_data <= mem[ptr];
          strm_last <= cnt == (ADDR_W+1)'(1);
          ptr <= ptr + 1'b1;
          cnt <= cnt - 1'b1;
        end
        strm_valid <= cnt != '0;
      end
    end
endmodule

// File: tb/tb_weight_memory_bank.sv
// tb_weight_memory_bank: directed bench with a queue-based reference model checked every cycle
module tb_weight_memory_bank;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int M_IDLE = 0, M_CLR = 1, M_STRM = 2;
  logic clk = 1'b0, rst_n = 1'b1;
  logic wr_en = 0, rd_en = 0, clr = 0, strm_start = 0, strm_ready = 1;
  logic [AW-1:0] wr_addr = 0, rd_addr = 0, strm_base = 0;
  logic [DW-1:0] wr_data = 0;
  logic [AW:0] strm_len = 0;
  logic [DW-1:0] rd_data, strm_data;
  logic rd_valid, strm_valid, strm_last, busy;
  int vectors = 0, miscompares = 0;
  int m_mode, m_clr_i, m_boot;
  logic [DW-1:0] m_mem [DEPTH];
  int m_q[$];
  logic m_rv, m_sv, m_sl;
  logic [DW-1:0] m_rd, m_sd;
  int got[$], gl[$], seen[$];

  weight_memory_bank #(.DATA_W(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .clr(clr),
    .strm_start(strm_start), .strm_base(strm_base), .strm_len(strm_len), .strm_data(strm_data),
    .strm_valid(strm_valid), .strm_ready(strm_ready), .strm_last(strm_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic present();
    int a;
    a = m_q.pop_front();
    m_sd = m_mem[a];
    m_sl = m_q.size() == 0;
    m_sv = 1'b1;
  endtask

  // reference model: reads happen before the write of the same edge (read-first)
  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_mode = M_IDLE; m_boot = 1; m_rv = 0; m_sv = 0; m_sl = 0; m_rd = 0; m_sd = 0; m_clr_i = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_IDLE; m_boot = 1; m_rv = 0; m_sv = 0; m_sl = 0; m_rd = 0; m_sd = 0;
        m_q.delete();
      end else begin
        int prev;
        prev = m_mode;
        m_rv = 0;
        if (m_mode == M_IDLE) begin
          if (m_boot != 0 || clr) begin
            m_mode = M_CLR; m_clr_i = 0;
          end else if (strm_start && strm_len >= 1 && strm_len <= DEPTH) begin
            m_q.delete();
            for (int k = 0; k < int'(strm_len); k++) m_q.push_back((int'(strm_base) + k) % DEPTH);
            m_mode = M_STRM;
            present();
          end else if (rd_en) begin
            m_rv = 1; m_rd = m_mem[rd_addr];
          end
        end else if (m_mode == M_CLR) begin
          m_mem[m_clr_i] = '0;
          m_clr_i++;
          if (m_clr_i == DEPTH) m_mode = M_IDLE;
        end else if (m_sv && strm_ready) begin
          if (m_sl) begin
            m_sv = 0; m_mode = M_IDLE;
          end else present();
        end
        if (prev != M_CLR && wr_en) m_mem[wr_addr] = wr_data;
        m_boot = 0;
      end
    end
  end

  // compare every cycle on the falling edge
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_outputs", {rd_data, strm_data, 4'b0, rd_valid, strm_valid, strm_last, busy}, 32'h0);
    end else begin
      chk("busy", busy, m_mode != M_IDLE);
      chk("rd_valid", rd_valid, m_rv);
      chk("rd_data", rd_data, m_rd);
      chk("strm_valid", strm_valid, m_sv);
      chk("strm_data", strm_data, m_sd);
      if (m_sv) chk("strm_last", strm_last, m_sl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_clear(input string nm);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n += int'(busy);
    end
    chk(nm, n, 16);
  endtask

  task automatic run_stream(input int base, input int len, input logic [31:0] stall, input logic hold_clr);
    got.delete(); gl.delete(); seen.delete();
    strm_base = AW'(base); strm_len = (AW+1)'(len); strm_start = 1; strm_ready = !stall[0];
    tick();
    strm_start = 0; clr = hold_clr;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      seen.push_back(int'(strm_data));
      if (strm_valid && strm_ready) begin
        got.push_back(int'(strm_data));
        gl.push_back(int'(strm_last));
        if (strm_last) begin
          clr = 0;
          break;
        end
      end
      tick();
      strm_ready = (c + 1 < 32) ? !stall[c+1] : 1'b1;
    end
    clr = 0;
    @(negedge clk);
    chk("busy_after_burst", busy, 0);
    strm_ready = 1;
  endtask

  task automatic check_burst(input string nm, input int n, input int first);
    chk({nm, "_count"}, got.size(), n);
    for (int k = 0; k < n; k++) begin
      chk({nm, "_data"}, k < got.size() ? got[k] : -1, (first + k) % DEPTH);
      chk({nm, "_last"}, k < gl.size() ? gl[k] : -1, k == n - 1);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i);
      tick();
    end
    wr_en = 0;
  endtask

  initial begin
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    count_clear("boot_clear_cycles");
    rd_en = 1; rd_addr = 5; tick(); rd_en = 0;
    @(negedge clk);
    chk("rd5_valid", rd_valid, 1);
    chk("rd5_data", rd_data, 8'h00);
    @(negedge clk);
    chk("rd_valid_pulse", rd_valid, 0);
    tick();
    wr_en = 1; wr_addr = 3; wr_data = 8'hA5; tick();
    wr_en = 0; rd_en = 1; rd_addr = 3; tick(); rd_en = 0;
    @(negedge clk);
    chk("rd3_after_wr", rd_data, 8'hA5);
    tick();
    wr_en = 1; wr_addr = 3; wr_data = 8'h5A; rd_en = 1; rd_addr = 3; tick();
    wr_en = 0; rd_en = 0;
    @(negedge clk);
    chk("rd3_read_first", rd_data, 8'hA5);
    tick();
    rd_en = 1; rd_addr = 3; tick(); rd_en = 0;
    @(negedge clk);
    chk("rd3_new", rd_data, 8'h5A);
    tick();
    load_ramp();
    run_stream(14, 4, 32'h0, 1'b0);
    check_burst("wrap", 4, 14);
    chk("wrap_cycles", seen.size(), 4);
    run_stream(14, 4, 32'hE, 1'b0);
    check_burst("stall", 4, 14);
    for (int c = 1; c <= 3; c++) chk("stall_hold", c < seen.size() ? seen[c] : -1, 15);
    run_stream(3, 0, 32'h0, 1'b0);
    chk("len0_none", got.size(), 0);
    run_stream(3, 17, 32'h0, 1'b0);
    chk("len17_none", got.size(), 0);
    run_stream(0, 16, 32'h0, 1'b0);
    check_burst("full", 16, 0);
    strm_base = 0; strm_len = 8; strm_start = 1; tick(); strm_start = 0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_strm_valid", strm_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    count_clear("reclear_cycles");
    rd_en = 1; rd_addr = 7; tick(); rd_en = 0;
    @(negedge clk);
    chk("rd7_cleared", rd_data, 8'h00);
    tick();
    load_ramp();
    run_stream(5, 3, 32'h0, 1'b1);
    check_burst("clr_ignored", 3, 5);
    repeat (3) @(negedge clk);
    chk("idle_after_clr_burst", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/weight_memory_bank.md
Name: weight_memory_bank

Overview:
- Parametrised weight store for the linear-regression datapath. Successor to the fixed 16x8 weight memory.
- Adds configurable width and depth, a registered random-read port with valid, and a hardware clear engine.
- Adds a burst-stream mode that feeds consecutive weights to the MAC through a valid/ready handshake.
- Sits between the host/training write path and the MAC array.

Parameters:
- DATA_W, 8, weight word width in bits.
- DEPTH, 16, number of weight entries; must be a power of 2 and at least 2. Localparam ADDR_W = clog2(DEPTH).
- CLEAR_ON_RESET, 1, when 1 the clear engine runs automatically after reset deassertion.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  random-read request
- rd_addr  in  ADDR_W  random-read address
- rd_data  out  DATA_W  random-read data
- rd_valid  out  1  one-cycle pulse marking rd_data valid
- clr  in  1  start clear of all entries
- strm_start  in  1  start burst stream
- strm_base  in  ADDR_W  first stream address
- strm_len  in  ADDR_W+1  number of words to stream, 1..DEPTH
- strm_data  out  DATA_W  stream word
- strm_valid  out  1  stream word valid
- strm_ready  in  1  consumer accepts the word
- strm_last  out  1  marks the final word of a burst, qualified by strm_valid
- busy  out  1  high in CLEAR or STREAM

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rd_data=0, rd_valid=0, strm_data=0, strm_valid=0, strm_last=0.
  - State IDLE; busy=0.
  - Memory array is not reset.
  - On the first clock after deassertion, if CLEAR_ON_RESET=1, the FSM enters CLEAR.
- States:
  - IDLE:
    - Command priority is clr > strm_start > rd_en.
    - clr -> CLEAR.
    - strm_start with strm_len in 1..DEPTH -> STREAM. Latch base and length.
    - strm_start with strm_len=0 or >DEPTH is ignored and the FSM stays in IDLE.
    - rd_en -> rd_data = mem[rd_addr] on the next edge, with rd_valid=1 for exactly that one cycle.
  - CLEAR:
    - Writes 0 to one entry per cycle, addresses 0 to DEPTH-1, for DEPTH cycles.
    - After the last entry the FSM returns to IDLE; busy falls on that transition.
    - wr_en, rd_en, strm_start and clr are ignored while in CLEAR.
  - STREAM:
    - Internal pointer starts at strm_base and increments modulo DEPTH, wrapping DEPTH-1 to 0.
    - The first word appears with strm_valid=1 one cycle after strm_start is accepted.
    - The output register loads the next word when strm_valid=0 or strm_ready=1.
    - While strm_valid=1 and strm_ready=0, strm_data and strm_last hold stable.
    - strm_last=1 on word number len.
    - On the transfer where strm_valid, strm_ready and strm_last are all 1, the FSM returns to IDLE and strm_valid falls the next cycle.
    - Sustained throughput with strm_ready held high is 1 word per cycle.
    - rd_en, strm_start and clr are ignored while in STREAM; no abort is supported.
- Writes:
  - Accepted in IDLE and STREAM: mem[wr_addr] <= wr_data at the clock edge.
  - Read-first semantics: a read or stream fetch of the same address in the same cycle returns the old data.
  - A write while rd_en is high is allowed.
- Output holding: rd_data holds its last value when no read occurs; strm_data holds after a burst ends.
- Reset mid-operation: any burst or clear is aborted immediately and all outputs return to their reset values.
  - A partially cleared array is re-cleared only if CLEAR_ON_RESET=1.
- Widths: no arithmetic on data. The stream counter is ADDR_W+1 bits wide so that strm_len=DEPTH can be represented.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16: busy=1 for 16 cycles, then 0. rd_en at addr 5 -> rd_data=0x00 with a one-cycle rd_valid pulse.
- Write 0xA5 to addr 3, then rd_en at addr 3 the next cycle -> rd_data=0xA5 one cycle later. Same-cycle write of 0x5A and read of addr 3 -> returns 0xA5.
- Load mem[i]=i. Stream base=14, len=4, ready high -> data 14,15,0,1 on 4 consecutive cycles; strm_last only on 1; busy falls after.
- Same burst with ready low on the 2nd word for 3 cycles -> strm_data=15 held stable and strm_valid held high. No word is lost or duplicated; total of 4 transfers.
- strm_len=0 and strm_len=17 -> no strm_valid and busy stays 0. strm_len=16 -> all 16 words streamed.
- Assert rst_n=0 mid-stream after 2 words -> strm_valid=0 immediately, then a clear runs. Assert clr during a stream -> ignored, burst completes.
